// File: rtl/seven_segment_display_selector_if.sv
// Display selector interface: control pulses, source buses and registered display outputs.
interface seven_segment_display_selector_if #(
  parameter int unsigned DECIMAL_DIGITS = 4,
  parameter int unsigned NUM_SOURCES    = 3,
  parameter int unsigned SEL_WIDTH      = 2
);
  localparam int unsigned DW = 4 * DECIMAL_DIGITS;

  logic                      i_Tick;
  logic                      i_Next;
  logic                      i_Sel_Valid;
  logic [SEL_WIDTH-1:0]      i_Sel;
  logic [NUM_SOURCES*DW-1:0] i_Time_Bus;
  logic [NUM_SOURCES-1:0]    i_PM_Bus;
  logic                      i_Blink_Req;
  logic [DW-1:0]             o_Display_Time;
  logic                      o_Display_PM;
  logic [SEL_WIDTH-1:0]      o_Source;
  logic                      o_Blank;

  modport master (
    output i_Tick, i_Next, i_Sel_Valid, i_Sel, i_Time_Bus, i_PM_Bus, i_Blink_Req,
    input  o_Display_Time, o_Display_PM, o_Source, o_Blank
  );

  modport slave (
    input  i_Tick, i_Next, i_Sel_Valid, i_Sel, i_Time_Bus, i_PM_Bus, i_Blink_Req,
    output o_Display_Time, o_Display_PM, o_Source, o_Blank
  );
endinterface

// File: rtl/seven_segment_display_selector.sv
// N-source BCD display selector with step/direct select and idle revert to source 0.
// Optional blanking blink is enabled by defining DISPLAY_BLINK_EN.
module seven_segment_display_selector #(
  parameter int unsigned DECIMAL_DIGITS = 4,
  parameter int unsigned NUM_SOURCES    = 3,
  parameter int unsigned SEL_WIDTH      = 2,
  parameter int unsigned TIMEOUT_TICKS  = 10,
  parameter int unsigned BLINK_TICKS    = 1
) (
  input logic                          i_Clk,
  input logic                          i_Rst_n,
  seven_segment_display_selector_if.slave sel_if
);
  localparam int unsigned DW     = 4 * DECIMAL_DIGITS;
  localparam int unsigned SELX_W = SEL_WIDTH + 1;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [0:0] ST_HOME   = 1'b0;
  localparam logic [0:0] ST_BROWSE = 1'b1;

  logic [0:0]           state, next_state;
  logic [SEL_WIDTH-1:0] src, next_src;
  logic [CNT_W-1:0]     cnt, next_cnt;
  logic                 sel_ok, accept, expire;
  logic [DW-1:0]        data_sel;
  logic                 pm_sel;
  logic                 out_blank;

  // Selection state register
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state <= ST_HOME;
      src   <= '0;
      cnt   <= '0;
    end else begin
      state <= next_state;
      src   <= next_src;
      cnt   <= next_cnt;
    end
  end

  // Next selection: valid direct select, then step, then idle timeout, else hold
  always_comb begin
    next_state = state;
    next_src   = src;
    next_cnt   = cnt;
    sel_ok     = sel_if.i_Sel_Valid &&
                 ({1'b0, sel_if.i_Sel} < SELX_W'(NUM_SOURCES));
    accept     = sel_ok || sel_if.i_Next;
    expire     = (state == ST_BROWSE) && sel_if.i_Tick &&
                 (cnt == CNT_W'(TIMEOUT_TICKS - 1));

    if (sel_ok) begin
      next_src = sel_if.i_Sel;
    end else if (sel_if.i_Next) begin
      next_src = (src == SEL_WIDTH'(NUM_SOURCES - 1)) ? '0 : src + SEL_WIDTH'(1);
    end else if (expire) begin
      next_src = '0;
    end

    if (accept || expire) begin
      next_cnt = '0;
    end else if ((state == ST_BROWSE) && sel_if.i_Tick) begin
      next_cnt = cnt + CNT_W'(1);
    end

    next_state = (next_src == '0) ? ST_HOME : ST_BROWSE;
  end

  // Source data mux driven from the next selection so outputs align with o_Source
  always_comb begin
    data_sel = sel_if.i_Time_Bus[int'(next_src)*DW +: DW];
    pm_sel   = sel_if.i_PM_Bus[int'(next_src)];
  end

`ifdef DISPLAY_BLINK_EN
  localparam int unsigned BCNT_W = $clog2(BLINK_TICKS + 1);

  logic [BCNT_W-1:0] bcnt, next_bcnt;
  logic              phase, next_phase;

  // Blink counter and phase register
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else begin
      bcnt  <= next_bcnt;
      phase <= next_phase;
    end
  end

  // Blink phase toggles every BLINK_TICKS ticks; a new selection restarts it visible
  always_comb begin
    next_bcnt  = bcnt;
    next_phase = phase;
    if (!sel_if.i_Blink_Req || accept) begin
      next_bcnt  = '0;
      next_phase = 1'b0;
    end else if (sel_if.i_Tick) begin
      if (bcnt == BCNT_W'(BLINK_TICKS - 1)) begin
        next_bcnt  = '0;
        next_phase = ~phase;
      end else begin
        next_bcnt  = bcnt + BCNT_W'(1);
      end
    end
    out_blank = next_phase;
  end
`else
  logic blink_unused;

  // Blink disabled: request ignored, never blank
  always_comb begin
    out_blank    = 1'b0;
    blink_unused = sel_if.i_Blink_Req ^ (BLINK_TICKS == 0);
  end
`endif

  // Registered display outputs
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      sel_if.o_Display_Time <= '0;
      sel_if.o_Display_PM   <= 1'b0;
      sel_if.o_Source       <= '0;
      sel_if.o_Blank        <= 1'b0;
    end else begin
      sel_if.o_Display_Time <= out_blank ? '1 : data_sel;
      sel_if.o_Display_PM   <= pm_sel & ~out_blank;
      sel_if.o_Source       <= next_src;
      sel_if.o_Blank        <= out_blank;
    end
  end
endmodule

// File: tb/tb_seven_segment_display_selector.sv
// Scoreboard bench for seven_segment_display_selector: directed cases then random traffic.
module tb_seven_segment_display_selector;
  localparam int unsigned DD = 4;
  localparam int unsigned NS = 3;
  localparam int unsigned SW = 2;
  localparam int unsigned TO = 10;
  localparam int unsigned BT = 1;
  localparam int unsigned DW = 4 * DD;
`ifdef DISPLAY_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] tm;
    logic          pm;
    logic [SW-1:0] src;
    logic          blank;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seven_segment_display_selector_if #(.DECIMAL_DIGITS(DD), .NUM_SOURCES(NS), .SEL_WIDTH(SW)) bus ();

  seven_segment_display_selector #(
    .DECIMAL_DIGITS(DD), .NUM_SOURCES(NS), .SEL_WIDTH(SW),
    .TIMEOUT_TICKS(TO), .BLINK_TICKS(BT)
  ) dut (
    .i_Clk  (clk),
    .i_Rst_n(rst_n),
    .sel_if (bus.slave)
  );

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [NS*DW-1:0] tb_time;
  logic [NS-1:0]    tb_pm;

  // Reference model: selection index, ticks idle since last selection, blink tick count
  int m_src = 0;
  int m_idle = 0;
  int m_bt = 0;
  bit m_ph = 1'b0;

  task automatic model_step(input bit rst, tick, nxt, sv, input int sel, input bit breq,
                            output exp_t e);
    bit acc;
    acc = 1'b0;
    if (!rst) begin
      m_src = 0; m_idle = 0; m_bt = 0; m_ph = 1'b0;
      e = '0;
      return;
    end
    if (sv && sel < NS) begin
      m_src = sel; acc = 1'b1;
    end else if (nxt) begin
      m_src = (m_src + 1) % NS; acc = 1'b1;
    end
    if (acc) m_idle = 0;
    else if (m_src != 0 && tick) begin
      m_idle++;
      if (m_idle == TO) begin
        m_src = 0; m_idle = 0;
      end
    end
    if (!breq || acc) begin
      m_bt = 0; m_ph = 1'b0;
    end else if (tick) begin
      m_bt++;
      if (m_bt == BT) begin
        m_bt = 0; m_ph = !m_ph;
      end
    end
    e.blank = BLINK_EN && m_ph;
    e.src   = SW'(m_src);
    e.tm    = e.blank ? {DW{1'b1}} : tb_time[m_src*DW +: DW];
    e.pm    = e.blank ? 1'b0 : tb_pm[m_src];
  endtask

  // Apply one cycle of stimulus at the falling edge and queue the expected result
  task automatic drive(input bit rst, tick, nxt, sv, input int sel, input bit breq);
    exp_t e;
    @(negedge clk);
    rst_n           = rst;
    bus.i_Tick      = tick;
    bus.i_Next      = nxt;
    bus.i_Sel_Valid = sv;
    bus.i_Sel       = SW'(sel);
    bus.i_Blink_Req = breq;
    bus.i_Time_Bus  = tb_time;
    bus.i_PM_Bus    = tb_pm;
    model_step(rst, tick, nxt, sv, sel, breq, e);
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0);
  endtask

  // Monitor: output is presented every edge; compare it with the oldest expectation
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = '{tm: bus.o_Display_Time, pm: bus.o_Display_PM, src: bus.o_Source,
              blank: bus.o_Blank};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL outputs t=%0t got src=%0d time=%h pm=%b blank=%b required src=%0d time=%h pm=%b blank=%b",
                   $time, a.src, a.tm, a.pm, a.blank, e.src, e.tm, e.pm, e.blank);
        end
      end
    end
  end

  initial begin
    int sel, r;
    bit tick, nxt, sv, breq, rst;
    rst_n = 1'b0;
    bus.i_Tick = 0; bus.i_Next = 0; bus.i_Sel_Valid = 0; bus.i_Sel = '0;
    bus.i_Blink_Req = 0; bus.i_Time_Bus = '0; bus.i_PM_Bus = '0;
    tb_time = {16'h0545, 16'h1230, 16'h0700};
    tb_pm   = 3'b010;

    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    idle(1);
    // Step through all sources with wrap
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 1, 0, 0, 0);
      idle(1);
    end
    // Direct select beats step; out-of-range select ignored
    drive(1, 0, 1, 1, 2, 0);
    idle(1);
    drive(1, 0, 0, 1, 3, 0);
    idle(1);
    // Timeout after TO ticks
    drive(1, 0, 0, 1, 1, 0);
    for (int k = 0; k < TO - 1; k++) drive(1, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    idle(2);
    // Step on the expiring tick wins
    drive(1, 0, 0, 1, 1, 0);
    for (int k = 0; k < TO - 1; k++) drive(1, 1, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0);
    for (int k = 0; k < TO - 1; k++) drive(1, 1, 0, 0, 0, 0);
    idle(1);
    // Data follow on the selected slice
    drive(1, 0, 0, 1, 1, 0);
    tb_time[DW +: DW] = 16'h1231;
    idle(2);
    // Reset mid-browse
    drive(1, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    idle(1);
    // Blink request with ticks, then drop it
    drive(1, 0, 0, 1, 2, 0);
    for (int k = 0; k < 6; k++) drive(1, 1, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0);
    idle(1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r    = $urandom_range(0, 99);
      rst  = (r != 0);
      tick = ($urandom_range(0, 2) == 0);
      nxt  = ($urandom_range(0, 9) == 0);
      sv   = ($urandom_range(0, 14) == 0);
      sel  = $urandom_range(0, 3);
      breq = ($urandom_range(0, 3) != 0);
      if (sv && sel >= NS) begin
        nxt = 0; tick = 0;
      end
      if ($urandom_range(0, 9) == 0) tb_time = {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) tb_pm = NS'($urandom);
      drive(rst, tick, nxt, sv, sel, breq);
    end

    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain left=%0d required=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
